// File: rtl/fp_addsub_pipe.sv
// ---------------------------------------------------------------------------
// fp_addsub_pipe
//
// Three-stage pipelined IEEE-754 floating-point adder/subtractor with
// generic exponent/fraction widths, round-to-nearest-even, gradual underflow,
// IEEE exception flags and a valid/ready handshake on both sides.
//
//   Stage 1 : unpack, classify specials, order by magnitude, align smaller
//   Stage 2 : add or subtract the aligned magnitudes (carry kept)
//   Stage 3 : normalise, round, pack, raise flags (registered outputs)
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   i_a, i_b     operands, W = 1+EXP_W+MAN_W bits
//   i_sub        1 = A-B, 0 = A+B (sampled with i_vld)
//   i_vld        operand valid
//   o_rdy        operands accepted this cycle when high
//   o_res        result
//   o_res_vld    result valid
//   i_res_rdy    downstream accepts result
//   o_overflow   result overflowed to infinity
//   o_underflow  result tiny (subnormal or zero) and inexact
//   o_inexact    rounding discarded nonzero bits
//   o_invalid    invalid operation (sNaN input or inf-inf)
//
// Optional feature (compile-time macro FP_FTZ_EN):
//   When defined, subnormal inputs are flushed to signed zero during unpack,
//   and any result that would be subnormal is flushed to signed zero with
//   o_underflow and o_inexact set. The normalise shifter is then unlimited.
// ---------------------------------------------------------------------------
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EXP_W+MAN_W:0] i_a,
  input  logic [EXP_W+MAN_W:0] i_b,
  input  logic                 i_sub,
  input  logic                 i_vld,
  output logic                 o_rdy,
  output logic [EXP_W+MAN_W:0] o_res,
  output logic                 o_res_vld,
  input  logic                 i_res_rdy,
  output logic                 o_overflow,
  output logic                 o_underflow,
  output logic                 o_inexact,
  output logic                 o_invalid
);

  // Aligned mantissa layout: [M-1] hidden, [M-2:3] fraction, [2] G, [1] R, [0] S
  localparam int M = MAN_W + 4;
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [EXP_W+MAN_W:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Whole pipe advances together; it only stalls when a result is waiting.
  logic w_en;
  assign w_en  = !o_res_vld || i_res_rdy;
  assign o_rdy = w_en;

  // ---------------------------------------------------------------------
  // Stage 1 combinational: unpack, classify, order and align
  // ---------------------------------------------------------------------
  logic             w_signA, w_signB;
  logic [EXP_W-1:0] w_expA, w_expB;
  logic [MAN_W-1:0] w_fracA, w_fracB;
  logic [MAN_W-1:0] w_fracAz, w_fracBz;
  logic             w_nanA, w_nanB, w_snanA, w_snanB, w_infA, w_infB;
  logic [EXP_W-1:0] w_effExpA, w_effExpB;
  logic [M-1:0]     w_mantA, w_mantB;
  logic             w_aGeB;

  // Operand B carries the subtract request folded into its sign.
  always_comb begin
    w_signA = i_a[EXP_W+MAN_W];
    w_signB = i_b[EXP_W+MAN_W] ^ i_sub;
    w_expA  = i_a[EXP_W+MAN_W-1:MAN_W];
    w_expB  = i_b[EXP_W+MAN_W-1:MAN_W];
    w_fracA = i_a[MAN_W-1:0];
    w_fracB = i_b[MAN_W-1:0];

    w_nanA  = (w_expA == EXP_ONES) && (w_fracA != '0);
    w_nanB  = (w_expB == EXP_ONES) && (w_fracB != '0);
    w_snanA = w_nanA && !w_fracA[MAN_W-1];
    w_snanB = w_nanB && !w_fracB[MAN_W-1];
    w_infA  = (w_expA == EXP_ONES) && (w_fracA == '0);
    w_infB  = (w_expB == EXP_ONES) && (w_fracB == '0);

`ifdef FP_FTZ_EN
    w_fracAz = (w_expA == '0) ? '0 : w_fracA;
    w_fracBz = (w_expB == '0) ? '0 : w_fracB;
`else
    w_fracAz = w_fracA;
    w_fracBz = w_fracB;
`endif

    // Subnormals live at exponent 1 with no hidden bit.
    w_effExpA = (w_expA == '0) ? EXP_ONE : w_expA;
    w_effExpB = (w_expB == '0) ? EXP_ONE : w_expB;
    w_mantA   = {(w_expA != '0), w_fracAz, 3'b000};
    w_mantB   = {(w_expB != '0), w_fracBz, 3'b000};

    // Ties keep A first, so equal magnitudes take A's sign.
    w_aGeB = {w_expA, w_fracAz} >= {w_expB, w_fracBz};
  end

  logic             w_signBig, w_signSmall;
  logic [EXP_W-1:0] w_expBig, w_expSmall, w_diff;
  logic [M-1:0]     w_mantBig, w_mantSmall, w_aligned, w_lostMask;

  // Right-shift the smaller magnitude; everything shifted out is ORed into S.
  always_comb begin
    w_signBig   = w_aGeB ? w_signA   : w_signB;
    w_signSmall = w_aGeB ? w_signB   : w_signA;
    w_expBig    = w_aGeB ? w_effExpA : w_effExpB;
    w_expSmall  = w_aGeB ? w_effExpB : w_effExpA;
    w_mantBig   = w_aGeB ? w_mantA   : w_mantB;
    w_mantSmall = w_aGeB ? w_mantB   : w_mantA;
    w_diff      = w_expBig - w_expSmall;
    w_lostMask  = '0;
    if (int'(w_diff) >= M - 1) begin
      w_aligned = {{(M-1){1'b0}}, |w_mantSmall};
    end else begin
      w_lostMask   = ~({M{1'b1}} << w_diff);
      w_aligned    = w_mantSmall >> w_diff;
      w_aligned[0] = w_aligned[0] | (|(w_mantSmall & w_lostMask));
    end
  end

  logic                 w_special, w_specInv;
  logic [EXP_W+MAN_W:0] w_specRes;

  // Specials are resolved up front and carried to the output untouched.
  always_comb begin
    w_special = 1'b0;
    w_specInv = 1'b0;
    w_specRes = '0;
    if (w_nanA || w_nanB) begin
      w_special = 1'b1;
      w_specRes = QNAN;
      w_specInv = w_snanA || w_snanB;
    end else if (w_infA && w_infB && (w_signA != w_signB)) begin
      w_special = 1'b1;
      w_specRes = QNAN;
      w_specInv = 1'b1;
    end else if (w_infA) begin
      w_special = 1'b1;
      w_specRes = {w_signA, EXP_ONES, {MAN_W{1'b0}}};
    end else if (w_infB) begin
      w_special = 1'b1;
      w_specRes = {w_signB, EXP_ONES, {MAN_W{1'b0}}};
    end
  end

  logic                 r_s1Vld, r_s1Sign, r_s1Sub, r_s1Special, r_s1SpecInv;
  logic [EXP_W-1:0]     r_s1Exp;
  logic [M-1:0]         r_s1MantBig, r_s1MantSmall;
  logic [EXP_W+MAN_W:0] r_s1SpecRes;

  // Stage 1 registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1Vld       <= 1'b0;
      r_s1Sign      <= 1'b0;
      r_s1Sub       <= 1'b0;
      r_s1Special   <= 1'b0;
      r_s1SpecInv   <= 1'b0;
      r_s1Exp       <= '0;
      r_s1MantBig   <= '0;
      r_s1MantSmall <= '0;
      r_s1SpecRes   <= '0;
    end else if (w_en) begin
      r_s1Vld       <= i_vld;
      r_s1Sign      <= w_signBig;
      r_s1Sub       <= w_signBig != w_signSmall;
      r_s1Special   <= w_special;
      r_s1SpecInv   <= w_specInv;
      r_s1Exp       <= w_expBig;
      r_s1MantBig   <= w_mantBig;
      r_s1MantSmall <= w_aligned;
      r_s1SpecRes   <= w_specRes;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: magnitude add/subtract (big >= small, so never negative)
  // ---------------------------------------------------------------------
  logic [M:0] w_sum;
  assign w_sum = r_s1Sub ? ({1'b0, r_s1MantBig} - {1'b0, r_s1MantSmall})
                         : ({1'b0, r_s1MantBig} + {1'b0, r_s1MantSmall});

  logic                 r_s2Vld, r_s2Sign, r_s2Sub, r_s2Special, r_s2SpecInv;
  logic [EXP_W-1:0]     r_s2Exp;
  logic [M:0]           r_s2Sum;
  logic [EXP_W+MAN_W:0] r_s2SpecRes;

  // Stage 2 registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2Vld     <= 1'b0;
      r_s2Sign    <= 1'b0;
      r_s2Sub     <= 1'b0;
      r_s2Special <= 1'b0;
      r_s2SpecInv <= 1'b0;
      r_s2Exp     <= '0;
      r_s2Sum     <= '0;
      r_s2SpecRes <= '0;
    end else if (w_en) begin
      r_s2Vld     <= r_s1Vld;
      r_s2Sign    <= r_s1Sign;
      r_s2Sub     <= r_s1Sub;
      r_s2Special <= r_s1Special;
      r_s2SpecInv <= r_s1SpecInv;
      r_s2Exp     <= r_s1Exp;
      r_s2Sum     <= w_sum;
      r_s2SpecRes <= r_s1SpecRes;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 3 combinational: normalise, round, pack, flags
  // ---------------------------------------------------------------------
  int                   w_lzc, w_expWide, w_shift, w_expN, w_expR;
  logic [M-1:0]         w_norm;
  logic                 w_guard, w_sticky, w_roundUp, w_inexactR, w_hidden;
  logic [MAN_W+1:0]     w_rounded;
  logic [MAN_W-1:0]     w_frac;
  logic [EXP_W-1:0]     w_expField;
  logic [EXP_W+MAN_W:0] w_res;
  logic                 w_ovf, w_unf, w_inex, w_inv;

  always_comb begin
    // Leading zeros above the carry position; M means the sum is zero.
    w_lzc = M;
    for (int i = 0; i < M; i++) begin
      if (r_s2Sum[i]) w_lzc = M - 1 - i;
    end

    w_expWide = int'(r_s2Exp);
    w_shift   = 0;
    if (r_s2Sum[M]) begin
      // Carry out: one step right, dropped bit joins sticky.
      w_norm = {r_s2Sum[M:2], r_s2Sum[1] | r_s2Sum[0]};
      w_expN = w_expWide + 1;
    end else begin
`ifdef FP_FTZ_EN
      w_shift = w_lzc;
`else
      // Stop at exponent 1 so tiny results stay subnormal.
      w_shift = (w_lzc < w_expWide - 1) ? w_lzc : w_expWide - 1;
`endif
      w_norm = r_s2Sum[M-1:0] << w_shift;
      w_expN = w_expWide - w_shift;
    end

    // Round to nearest even: R and S collapse into one sticky.
    w_guard    = w_norm[2];
    w_sticky   = w_norm[1] | w_norm[0];
    w_roundUp  = w_guard & (w_sticky | w_norm[3]);
    w_inexactR = w_guard | w_sticky;
    w_rounded  = {1'b0, w_norm[M-1:3]} + {{(MAN_W+1){1'b0}}, w_roundUp};
    w_expR     = w_expN + int'(w_rounded[MAN_W+1]);
    w_hidden   = w_rounded[MAN_W+1] | w_rounded[MAN_W];
    w_frac     = w_rounded[MAN_W+1] ? w_rounded[MAN_W:1] : w_rounded[MAN_W-1:0];
    w_expField = w_hidden ? w_expR[EXP_W-1:0] : {EXP_W{1'b0}};

    w_res  = {r_s2Sign, w_expField, w_frac};
    w_ovf  = 1'b0;
    w_inex = w_inexactR;
    w_unf  = !w_hidden && w_inexactR;
    w_inv  = 1'b0;

    if (r_s2Special) begin
      w_res  = r_s2SpecRes;
      w_inex = 1'b0;
      w_unf  = 1'b0;
      w_inv  = r_s2SpecInv;
    end else if (r_s2Sum == '0) begin
      // Cancellation gives +0; only same-sign zeros keep their sign.
      w_res  = {r_s2Sign & !r_s2Sub, {(EXP_W+MAN_W){1'b0}}};
      w_inex = 1'b0;
      w_unf  = 1'b0;
`ifdef FP_FTZ_EN
    end else if (w_expN < 1) begin
      w_res  = {r_s2Sign, {(EXP_W+MAN_W){1'b0}}};
      w_inex = 1'b1;
      w_unf  = 1'b1;
`endif
    end else if (w_expR >= int'(EXP_ONES)) begin
      w_res  = {r_s2Sign, EXP_ONES, {MAN_W{1'b0}}};
      w_ovf  = 1'b1;
      w_inex = 1'b1;
      w_unf  = 1'b0;
    end
  end

  // Output registers; result and flags only change when a valid op lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_res_vld   <= 1'b0;
      o_res       <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
      o_inexact   <= 1'b0;
      o_invalid   <= 1'b0;
    end else if (w_en) begin
      o_res_vld <= r_s2Vld;
      if (r_s2Vld) begin
        o_res       <= w_res;
        o_overflow  <= w_ovf;
        o_underflow <= w_unf;
        o_inexact   <= w_inex;
        o_invalid   <= w_inv;
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// ---------------------------------------------------------------------------
// tb_fp_addsub_pipe
//
// Scoreboard bench for fp_addsub_pipe at default widths (binary32). Expected
// results are queued as operands are accepted and compared as results are
// consumed. Flags are compared as {overflow, underflow, inexact, invalid}.
// Honours FP_FTZ_EN for the subnormal vectors.
// ---------------------------------------------------------------------------
module tb_fp_addsub_pipe;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flg;
  } expT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_a, i_b;
  logic        i_sub, i_vld, i_res_rdy;
  logic        o_rdy, o_res_vld;
  logic [31:0] o_res;
  logic        o_overflow, o_underflow, o_inexact, o_invalid;

  expT expQ[$];
  int  checks = 0;
  int  errors = 0;
  int  popped = 0;

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_a         (i_a),
    .i_b         (i_b),
    .i_sub       (i_sub),
    .i_vld       (i_vld),
    .o_rdy       (o_rdy),
    .o_res       (o_res),
    .o_res_vld   (o_res_vld),
    .i_res_rdy   (i_res_rdy),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow),
    .o_inexact   (o_inexact),
    .o_invalid   (o_invalid)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one operation (called just after a rising edge); wait for o_rdy,
  // queue the expected result at the edge that accepts it.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic sub, input logic [31:0] expRes,
                               input logic [3:0] expFlg);
    int  waitCycles;
    expT e;
    waitCycles = 0;
    i_a   = a;
    i_b   = b;
    i_sub = sub;
    i_vld = 1'b1;
    @(negedge clk);
    while (!o_rdy && waitCycles < 200) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!o_rdy) begin
      checkOutput("rdy_timeout", 64'(o_rdy), 64'd1);
    end else begin
      e.res = expRes;
      e.flg = expFlg;
      expQ.push_back(e);
    end
    @(posedge clk);
    #1;
    i_vld = 1'b0;
  endtask

  // Bounded wait for every queued result to come out.
  task automatic waitForDrain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("drain_left", 64'(expQ.size()), 64'd0);
  endtask

  // Monitor: a result is consumed on the next edge when valid and ready.
  always @(negedge clk) begin
    if (rst && o_res_vld && i_res_rdy) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_vld", 64'(o_res_vld), 64'd0);
      end else begin
        expT e;
        e = expQ.pop_front();
        checkOutput($sformatf("res%0d", popped), 64'(o_res), 64'(e.res));
        checkOutput($sformatf("flags%0d", popped),
                    64'({o_overflow, o_underflow, o_inexact, o_invalid}), 64'(e.flg));
        popped++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_a = '0;
    i_b = '0;
    i_sub = 1'b0;
    i_vld = 1'b0;
    i_res_rdy = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_vld", 64'(o_res_vld), 64'd0);
    checkOutput("rst_res", 64'(o_res), 64'd0);
    checkOutput("rst_flags", 64'({o_overflow, o_underflow, o_inexact, o_invalid}), 64'd0);
    checkOutput("rst_rdy", 64'(o_rdy), 64'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed vectors");
    applyStimulus(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
    applyStimulus(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
    applyStimulus(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
    applyStimulus(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b1010);
    applyStimulus(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b0001);
    applyStimulus(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0010);
    applyStimulus(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0010);
    applyStimulus(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000);
    applyStimulus(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000);
    applyStimulus(32'h7FA00000, 32'h00000000, 1'b0, 32'h7FC00000, 4'b0001);
    applyStimulus(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000);
    applyStimulus(32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000);
    applyStimulus(32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 4'b0000);
    applyStimulus(32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 4'b0000);
    applyStimulus(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000);
`ifdef FP_FTZ_EN
    applyStimulus(32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 4'b0000);
    applyStimulus(32'h00800000, 32'h00000001, 1'b1, 32'h00800000, 4'b0000);
`else
    applyStimulus(32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'b0000);
    applyStimulus(32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 4'b0000);
`endif
    waitForDrain();

    $display("[TB] backpressure");
    @(posedge clk);
    #1 i_res_rdy = 1'b0;
    fork
      begin
        applyStimulus(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
        applyStimulus(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000);
        applyStimulus(32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 4'b0000);
        applyStimulus(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000);
      end
      begin : releaser
        int n;
        n = 0;
        @(negedge clk);
        while (!o_res_vld && n < 20) begin
          @(negedge clk);
          n++;
        end
        checkOutput("bp_fill", 64'(o_res_vld), 64'd1);
        repeat (4) begin
          checkOutput("bp_hold_res", 64'(o_res), 64'h40400000);
          checkOutput("bp_hold_rdy", 64'(o_rdy), 64'd0);
          @(negedge clk);
        end
        @(posedge clk);
        #1 i_res_rdy = 1'b1;
      end
    join
    waitForDrain();
    checkOutput("bp_popped", 64'(popped), 64'd21);

    $display("[TB] reset mid-stream");
    @(posedge clk);
    #1;
    applyStimulus(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
    applyStimulus(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000);
    applyStimulus(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("midrst_vld", 64'(o_res_vld), 64'd0);
    checkOutput("midrst_res", 64'(o_res), 64'd0);
    expQ.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      checkOutput("postrst_vld", 64'(o_res_vld), 64'd0);
    end

    $display("[TB] recovery");
    @(posedge clk);
    #1;
    applyStimulus(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
    waitForDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
